// File: rtl/clock_input_pkg.sv
// rtl/clock_input_pkg.sv - shared constants and types for the alarm clock input front end
// Ports: none (package).
package clock_input_pkg;

  localparam int NUM_BTN      = 5;
  localparam int BTN_TIMESET  = 0;
  localparam int BTN_ALARMSET = 1;
  localparam int BTN_MINADV   = 2;
  localparam int BTN_HRSADV   = 3;
  localparam int BTN_ALARMON  = 4;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RPT
  } rpt_state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_input_cond_if.sv
// rtl/clock_input_cond_if.sv - button/strobe bundle between input conditioning and its neighbours
// Signals: btn_raw (raw buttons in), pulse (seconds strobe), btn_lvl (debounced levels),
//          min_adv / hrs_adv (advance strobes).
// Modports: slave = conditioning block, master = the side driving buttons and consuming strobes.
interface clock_input_cond_if;
  import clock_input_pkg::*;

  logic [NUM_BTN-1:0] btn_raw;
  logic               pulse;
  logic [NUM_BTN-1:0] btn_lvl;
  logic               min_adv;
  logic               hrs_adv;

  modport master (
    output btn_raw,
    input  pulse,
    input  btn_lvl,
    input  min_adv,
    input  hrs_adv
  );

  modport slave (
    input  btn_raw,
    output pulse,
    output btn_lvl,
    output min_adv,
    output hrs_adv
  );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer plus stable-count debounce for one button
// Ports: clk (clock), rst (async active-low reset), raw (asynchronous button),
//        lvl (debounced level, changes DB_CYCLES+2 cycles after a clean raw edge).
module btn_debounce
  import clock_input_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl
);

  localparam int             CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      // Any cycle where the synchronized value agrees with the accepted level
      // restarts the stability count, so a bounce back discards progress.
      if (r_sync2 == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_lvl <= ~r_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign lvl = r_lvl;

endmodule

// File: rtl/clock_input_cond.sv
// rtl/clock_input_cond.sv - seconds prescaler, button debounce and advance auto-repeat
// Ports: clk (board clock), rst (async active-low reset),
//        bus (slave side: btn_raw in; pulse, btn_lvl, min_adv, hrs_adv out).
module clock_input_cond
  import clock_input_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int RPT_DLY   = 25_000_000,
  parameter int RPT_PER   = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  clock_input_cond_if.slave   bus
);

  // ---------------------------------------------------------------- prescaler
  localparam int            TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Decode of a register; TICK_DIV >= 2 keeps it low while in reset.
  assign bus.pulse = (r_tick_cnt == TICK_LAST);

  // ----------------------------------------------------------------- debounce
  logic [NUM_BTN-1:0] w_btn_lvl;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk (clk),
      .rst (rst),
      .raw (bus.btn_raw[gi]),
      .lvl (w_btn_lvl[gi])
    );
  end

  assign bus.btn_lvl = w_btn_lvl;

  // ------------------------------------------------------ auto-repeat FSMs
  // One shared counter per FSM covers both the initial hold delay and the
  // repeat period, so it is sized for the larger of the two.
  localparam int RW_DLY = cnt_width(RPT_DLY);
  localparam int RW_PER = cnt_width(RPT_PER);
  localparam int RW     = (RW_DLY > RW_PER) ? RW_DLY : RW_PER;
  localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DLY - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(RPT_PER - 1);

  logic [1:0] w_adv_lvl;
  logic [1:0] w_adv;

  assign w_adv_lvl[0] = w_btn_lvl[BTN_MINADV];
  assign w_adv_lvl[1] = w_btn_lvl[BTN_HRSADV];

  for (genvar gr = 0; gr < 2; gr++) begin : g_rpt
    rpt_state_t    r_state;
    logic [RW-1:0] r_cnt;
    logic          r_lvl_d;
    logic          r_adv;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_lvl_d <= 1'b0;
        r_adv   <= 1'b0;
      end else begin
        r_lvl_d <= w_adv_lvl[gr];
        r_adv   <= 1'b0;
        case (r_state)
          IDLE: begin
            if (w_adv_lvl[gr] && !r_lvl_d) begin
              r_adv   <= 1'b1;
              r_cnt   <= '0;
              r_state <= HOLD;
            end
          end
          HOLD: begin
            // Release is checked first so it wins over a terminal count.
            if (!w_adv_lvl[gr]) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else if (r_cnt == DLY_LAST) begin
              r_adv   <= 1'b1;
              r_cnt   <= '0;
              r_state <= RPT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          RPT: begin
            if (!w_adv_lvl[gr]) begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end else if (r_cnt == PER_LAST) begin
              r_adv <= 1'b1;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end
        endcase
      end
    end

    assign w_adv[gr] = r_adv;
  end

  assign bus.min_adv = w_adv[0];
  assign bus.hrs_adv = w_adv[1];

endmodule

// File: tb/tb_clock_input_cond.sv
// tb/tb_clock_input_cond.sv - directed vector bench for clock_input_cond
module tb_clock_input_cond;

  logic clk;
  logic rst_n;

  clock_input_cond_if u_if ();

  clock_input_cond #(
    .TICK_DIV  (10),
    .DB_CYCLES (4),
    .RPT_DLY   (20),
    .RPT_PER   (5)
  ) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit in_rst = 1'b1;

  typedef struct {
    logic [4:0] raw;
    logic [4:0] lvl;
    logic       mn;
    logic       hr;
  } vec_t;

  vec_t tbl[$];

  logic [4:0] seq_raw [0:199];
  bit         exp_min [0:199];
  bit         exp_hrs [0:199];
  int         cnt_min;
  int         cnt_hrs;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cyc %0d): got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One clock; outputs are examined 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (in_rst) begin
      chk("pulse_in_reset", u_if.pulse, 0);
      chk("lvl_in_reset", u_if.btn_lvl, 0);
      chk("min_in_reset", u_if.min_adv, 0);
      chk("hrs_in_reset", u_if.hrs_adv, 0);
    end else begin
      cyc++;
      chk("pulse", u_if.pulse, (cyc % 10 == 9));
    end
  endtask

  task automatic add(input logic [4:0] r, input logic [4:0] l,
                     input logic m, input logic h, input int n);
    vec_t v;
    v.raw = r;
    v.lvl = l;
    v.mn  = m;
    v.hr  = h;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic clear_seq();
    for (int i = 0; i < 200; i++) begin
      seq_raw[i] = 5'b0;
      exp_min[i] = 1'b0;
      exp_hrs[i] = 1'b0;
    end
  endtask

  task automatic set_raw(input int from, input int to, input logic [4:0] v);
    for (int i = from; i <= to; i++) seq_raw[i] = v;
  endtask

  task automatic run_seq(input string nm, input int n);
    cnt_min = 0;
    cnt_hrs = 0;
    for (int k = 1; k <= n; k++) begin
      u_if.btn_raw = seq_raw[k];
      step();
      chk({nm, "_min"}, u_if.min_adv, exp_min[k]);
      chk({nm, "_hrs"}, u_if.hrs_adv, exp_hrs[k]);
      if (u_if.min_adv) cnt_min++;
      if (u_if.hrs_adv) cnt_hrs++;
    end
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int npulse;

    rst_n       = 1'b0;
    u_if.btn_raw = 5'b0;
    step();
    step();
    rst_n  = 1'b1;
    in_rst = 1'b0;
    cyc    = 0;

    // Prescaler: 10 pulses in 100 cycles, buttons idle.
    npulse = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (u_if.pulse) npulse++;
      if (k % 25 == 0) chk("idle_lvl", u_if.btn_lvl, 0);
    end
    chk("pulse_count", npulse, 10);

    // Vector table: bounce rejection, exact-length acceptance, single press.
    add(5'b00001, 5'b00000, 0, 0, 1);   // 1-cycle glitch
    add(5'b00000, 5'b00000, 0, 0, 4);
    add(5'b00001, 5'b00000, 0, 0, 3);   // 3-cycle pulse, one short of accept
    add(5'b00000, 5'b00000, 0, 0, 6);
    add(5'b00001, 5'b00000, 0, 0, 5);   // clean hold: rises on 6th cycle
    add(5'b00001, 5'b00001, 0, 0, 5);
    add(5'b00000, 5'b00001, 0, 0, 5);   // release: falls on 6th cycle
    add(5'b00000, 5'b00000, 0, 0, 3);
    add(5'b10000, 5'b00000, 0, 0, 4);   // 4-cycle pulse on Alarmon is accepted
    add(5'b00000, 5'b00000, 0, 0, 1);
    add(5'b00000, 5'b10000, 0, 0, 4);
    add(5'b00000, 5'b00000, 0, 0, 3);
    add(5'b00100, 5'b00000, 0, 0, 5);   // Minadv held 15 cycles
    add(5'b00100, 5'b00100, 0, 0, 1);
    add(5'b00100, 5'b00100, 1, 0, 1);
    add(5'b00100, 5'b00100, 0, 0, 8);
    add(5'b00000, 5'b00100, 0, 0, 5);
    add(5'b00000, 5'b00000, 0, 0, 5);
    foreach (tbl[i]) begin
      u_if.btn_raw = tbl[i].raw;
      step();
      chk($sformatf("tbl%0d_lvl", i), u_if.btn_lvl, tbl[i].lvl);
      chk($sformatf("tbl%0d_min", i), u_if.min_adv, tbl[i].mn);
      chk($sformatf("tbl%0d_hrs", i), u_if.hrs_adv, tbl[i].hr);
    end

    // Auto-repeat on Hrsadv: level high for 50 cycles.
    clear_seq();
    set_raw(1, 50, 5'b01000);
    exp_hrs[7] = 1'b1;
    for (int t = 27; t <= 52; t += 5) exp_hrs[t] = 1'b1;
    run_seq("autorpt", 70);
    chk("autorpt_hrs_count", cnt_hrs, 7);
    chk("autorpt_min_count", cnt_min, 0);

    // Release in the cycle HOLD reaches its terminal count, then a fresh press.
    clear_seq();
    set_raw(1, 20, 5'b00100);
    set_raw(41, 50, 5'b00100);
    exp_min[7]  = 1'b1;
    exp_min[47] = 1'b1;
    run_seq("rel_tc", 65);
    chk("rel_tc_min_count", cnt_min, 2);

    // Reset while repeating with Minadv held.
    clear_seq();
    set_raw(1, 34, 5'b00100);
    exp_min[7]  = 1'b1;
    exp_min[27] = 1'b1;
    exp_min[32] = 1'b1;
    run_seq("pre_rst", 34);
    rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", u_if.pulse, 0);
    chk("async_rst_lvl", u_if.btn_lvl, 0);
    chk("async_rst_min", u_if.min_adv, 0);
    chk("async_rst_hrs", u_if.hrs_adv, 0);
    in_rst = 1'b1;
    step();
    step();
    step();
    rst_n  = 1'b1;
    in_rst = 1'b0;
    cyc    = 0;
    clear_seq();
    set_raw(1, 40, 5'b00100);
    exp_min[7] = 1'b1;
    for (int t = 27; t <= 42; t += 5) exp_min[t] = 1'b1;
    run_seq("post_rst", 55);
    chk("post_rst_min_count", cnt_min, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
